// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects finished results from NUM_EU execution units into per-EU result
//   FIFOs. It then broadcasts up to CDB_NUM_LANES FIFO heads per cycle on the
//   Common Data Bus, using a rotating (round-robin) scan order.
//
//   Optional build macro:
//     CDB_OUT_REG_EN  register the arbiter result before the CDB outputs
//                     (push at edge N -> broadcast in cycle N+2 instead of N+1)
//
//   Ports
//     clk, rst            clock; synchronous active-high reset
//     flush               drops every buffered result and restarts the scan at EU0
//     eu_val / eu_rdy     per-EU result handshake (eu_rdy = FIFO not full)
//     eu_rob_id, eu_op,   per-EU result payload, EU i at slice i
//     eu_rd_tag, eu_data
//     ROB_id_cdb, op_cdb, per-lane CDB broadcast; lane l at slice l
//     rd_tag_cdb,
//     result_data_cdb
//     commit_instr_cdb    per-lane valid, packed from lane 0 upward
module cdb_arbiter #(
  parameter int NUM_EU        = 4,
  parameter int CDB_NUM_LANES = 2,
  parameter int ROB_SIZE_CLOG = 5,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_EU-1:0]                      eu_val,
  output logic [NUM_EU-1:0]                      eu_rdy,
  input  logic [NUM_EU*ROB_SIZE_CLOG-1:0]        eu_rob_id,
  input  logic [NUM_EU*6-1:0]                    eu_op,
  input  logic [NUM_EU*5-1:0]                    eu_rd_tag,
  input  logic [NUM_EU*32-1:0]                   eu_data,
  output logic [CDB_NUM_LANES*ROB_SIZE_CLOG-1:0] ROB_id_cdb,
  output logic [CDB_NUM_LANES*6-1:0]             op_cdb,
  output logic [CDB_NUM_LANES*5-1:0]             rd_tag_cdb,
  output logic [CDB_NUM_LANES-1:0]               commit_instr_cdb,
  output logic [CDB_NUM_LANES*32-1:0]            result_data_cdb
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
  localparam int ENTW = ROB_SIZE_CLOG + 6 + 5 + 32;

  // FIFO entry layout: {rob_id, op, rd_tag, data}
  logic [ENTW-1:0] mem    [NUM_EU][FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr [NUM_EU];
  logic [PW-1:0]   wr_ptr [NUM_EU];
  logic [CW-1:0]   count  [NUM_EU];

  logic [EW-1:0]              rr_ptr;
  logic [EW-1:0]              rr_next;
  logic [NUM_EU-1:0]          push;
  logic [NUM_EU-1:0]          grant;
  logic [CDB_NUM_LANES-1:0]   lane_val;
  logic [ENTW-1:0]            lane_ent [CDB_NUM_LANES];
  logic [CDB_NUM_LANES-1:0]   out_val;
  logic [ENTW-1:0]            out_ent  [CDB_NUM_LANES];

  // Ready depends on occupancy only; a same-cycle pop does not free a slot.
  always_comb begin
    for (int unsigned i = 0; i < NUM_EU; i++) begin
      eu_rdy[i] = (count[i] < CW'(FIFO_DEPTH));
    end
    push = eu_val & eu_rdy;
  end

  // Rotating scan from rr_ptr; each nonempty head takes the next free lane.
  always_comb begin
    int unsigned  n;
    logic [EW-1:0] idx;
    n        = 0;
    idx      = '0;
    grant    = '0;
    lane_val = '0;
    rr_next  = rr_ptr;
    for (int unsigned l = 0; l < CDB_NUM_LANES; l++) begin
      lane_ent[l] = '0;
    end
    for (int unsigned k = 0; k < NUM_EU; k++) begin
      idx = EW'((32'(rr_ptr) + k) % NUM_EU);
      if (count[idx] != '0 && n < CDB_NUM_LANES) begin
        grant[idx] = 1'b1;
        for (int unsigned l = 0; l < CDB_NUM_LANES; l++) begin
          if (l == n) begin
            lane_val[l] = 1'b1;
            lane_ent[l] = mem[idx][rd_ptr[idx]];
          end
        end
        rr_next = EW'((32'(idx) + 1) % NUM_EU);
        n       = n + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr <= '0;
      for (int unsigned i = 0; i < NUM_EU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int unsigned i = 0; i < NUM_EU; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !grant[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && grant[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_EU; i++) begin
      if (!rst && !flush && push[i]) begin
        mem[i][wr_ptr[i]] <= {eu_rob_id[i*ROB_SIZE_CLOG +: ROB_SIZE_CLOG],
                              eu_op[i*6 +: 6], eu_rd_tag[i*5 +: 5],
                              eu_data[i*32 +: 32]};
      end
    end
  end

`ifdef CDB_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_val <= '0;
      for (int unsigned l = 0; l < CDB_NUM_LANES; l++) out_ent[l] <= '0;
    end else begin
      out_val <= lane_val;
      for (int unsigned l = 0; l < CDB_NUM_LANES; l++) out_ent[l] <= lane_ent[l];
    end
  end
`else
  always_comb begin
    out_val = lane_val;
    for (int unsigned l = 0; l < CDB_NUM_LANES; l++) out_ent[l] = lane_ent[l];
  end
`endif

  // Invalid lanes carry an all-zero entry, so every field reads 0.
  always_comb begin
    commit_instr_cdb = out_val;
    for (int unsigned l = 0; l < CDB_NUM_LANES; l++) begin
      {ROB_id_cdb[l*ROB_SIZE_CLOG +: ROB_SIZE_CLOG], op_cdb[l*6 +: 6],
       rd_tag_cdb[l*5 +: 5], result_data_cdb[l*32 +: 32]} = out_ent[l];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int NUM_EU = 4;
  localparam int LANES  = 2;
  localparam int RW     = 5;
  localparam int DEPTH  = 2;

  logic                  clk = 1'b0;
  logic                  rst, flush;
  logic [NUM_EU-1:0]     eu_val, eu_rdy;
  logic [NUM_EU*RW-1:0]  eu_rob_id;
  logic [NUM_EU*6-1:0]   eu_op;
  logic [NUM_EU*5-1:0]   eu_rd_tag;
  logic [NUM_EU*32-1:0]  eu_data;
  logic [LANES*RW-1:0]   ROB_id_cdb;
  logic [LANES*6-1:0]    op_cdb;
  logic [LANES*5-1:0]    rd_tag_cdb;
  logic [LANES-1:0]      commit_instr_cdb;
  logic [LANES*32-1:0]   result_data_cdb;

  cdb_arbiter #(.NUM_EU(NUM_EU), .CDB_NUM_LANES(LANES), .ROB_SIZE_CLOG(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .eu_val(eu_val), .eu_rdy(eu_rdy),
    .eu_rob_id(eu_rob_id), .eu_op(eu_op), .eu_rd_tag(eu_rd_tag), .eu_data(eu_data),
    .ROB_id_cdb(ROB_id_cdb), .op_cdb(op_cdb), .rd_tag_cdb(rd_tag_cdb),
    .commit_instr_cdb(commit_instr_cdb), .result_data_cdb(result_data_cdb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] id;
    logic [5:0]    op;
    logic [4:0]    rd;
    logic [31:0]   data;
  } res_t;

  // Reference model: one queue per EU, a scan start index, optional output regs
  res_t       q [NUM_EU][$];
  int         rr = 0;
  int         grant_eu[$];
  int         pushed_cnt [NUM_EU];
  res_t       cur_lane [LANES];
  logic [LANES-1:0] cur_val;
  res_t       reg_lane [LANES];
  logic [LANES-1:0] reg_val = '0;
  res_t       exp_lane [LANES];
  logic [LANES-1:0] exp_val;
  logic [NUM_EU-1:0] exp_rdy;
  bit         exp_on = 0;

  logic [31:0] obs[$];   // data of every lane the DUT broadcast (flush/rst cycles excluded)
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t rd_in(input int e);
    res_t r;
    r.id   = eu_rob_id[e*RW +: RW];
    r.op   = eu_op[e*6 +: 6];
    r.rd   = eu_rd_tag[e*5 +: 5];
    r.data = eu_data[e*32 +: 32];
    return r;
  endfunction

  task automatic compute();
    int n;
    int e;
    n = 0;
    grant_eu.delete();
    cur_val = '0;
    for (int l = 0; l < LANES; l++) cur_lane[l] = '0;
    for (int k = 0; k < NUM_EU; k++) begin
      e = (rr + k) % NUM_EU;
      if (q[e].size() > 0 && n < LANES) begin
        cur_lane[n] = q[e][0];
        cur_val[n]  = 1'b1;
        grant_eu.push_back(e);
        n++;
      end
    end
    for (int i = 0; i < NUM_EU; i++) exp_rdy[i] = (q[i].size() < DEPTH);
`ifdef CDB_OUT_REG_EN
    exp_lane = reg_lane;
    exp_val  = reg_val;
`else
    exp_lane = cur_lane;
    exp_val  = cur_val;
`endif
    exp_on = 1;
  endtask

  task automatic edge_update();
    bit   do_push [NUM_EU];
    res_t r;
    if (rst || flush) begin
      for (int e = 0; e < NUM_EU; e++) q[e].delete();
      rr = 0;
      reg_val = '0;
      for (int l = 0; l < LANES; l++) reg_lane[l] = '0;
    end else begin
      reg_val  = cur_val;
      reg_lane = cur_lane;
      for (int e = 0; e < NUM_EU; e++) do_push[e] = eu_val[e] && (q[e].size() < DEPTH);
      foreach (grant_eu[g]) r = q[grant_eu[g]].pop_front();
      if (grant_eu.size() > 0) rr = (grant_eu[grant_eu.size()-1] + 1) % NUM_EU;
      for (int e = 0; e < NUM_EU; e++) begin
        if (do_push[e]) begin
          q[e].push_back(rd_in(e));
          pushed_cnt[e]++;
        end
      end
    end
  endtask

  task automatic cycle();
    compute();
    @(posedge clk);
    edge_update();
    #1;
  endtask

  task automatic lat();
`ifdef CDB_OUT_REG_EN
    cycle();
`endif
  endtask

  task automatic drive(input int e, input logic v, input logic [RW-1:0] id, input logic [31:0] d);
    eu_val[e]              = v;
    eu_rob_id[e*RW +: RW]  = id;
    eu_op[e*6 +: 6]        = 6'($urandom);
    eu_rd_tag[e*5 +: 5]    = 5'($urandom);
    eu_data[e*32 +: 32]    = d;
  endtask

  task automatic idle();
    eu_val = '0;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Single compare process: DUT outputs vs. model on every cycle after reset is applied
  always @(negedge clk) begin
    if (exp_on) begin
      chk("commit_instr_cdb", 64'(commit_instr_cdb), 64'(exp_val));
      chk("eu_rdy", 64'(eu_rdy), 64'(exp_rdy));
      for (int l = 0; l < LANES; l++) begin
        chk($sformatf("rob_id_lane%0d", l), 64'(ROB_id_cdb[l*RW +: RW]), 64'(exp_lane[l].id));
        chk($sformatf("op_lane%0d", l), 64'(op_cdb[l*6 +: 6]), 64'(exp_lane[l].op));
        chk($sformatf("rd_tag_lane%0d", l), 64'(rd_tag_cdb[l*5 +: 5]), 64'(exp_lane[l].rd));
        chk($sformatf("data_lane%0d", l), 64'(result_data_cdb[l*32 +: 32]), 64'(exp_lane[l].data));
      end
    end
    if (!rst && !flush) begin
      for (int l = 0; l < LANES; l++)
        if (commit_instr_cdb[l] === 1'b1) obs.push_back(result_data_cdb[l*32 +: 32]);
    end
  end

  initial begin
    logic [31:0] got[$];
    int  base;
    bit  found;
    for (int e = 0; e < NUM_EU; e++) pushed_cnt[e] = 0;
    eu_rob_id = '0; eu_op = '0; eu_rd_tag = '0; eu_data = '0;
    flush = 1'b0;

    // 1. reset held two cycles with every EU offering a result
    rst = 1'b1;
    for (int e = 0; e < NUM_EU; e++) drive(e, 1'b1, 5'(e), 32'h5555_0000 + 32'(e));
    @(posedge clk);
    edge_update();
    #1;
    cycle();
    rst = 1'b0;
    idle();
    chk("t1_commit_after_rst", 64'(commit_instr_cdb), 64'h0);
    chk("t1_data_after_rst", 64'(result_data_cdb), 64'h0);
    chk("t1_rdy_after_rst", 64'(eu_rdy), 64'hF);
    drain(2);

    // 2. single result from EU2
    drive(2, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle();
    idle();
    lat();
    chk("t2_commit", 64'(commit_instr_cdb), 64'b01);
    chk("t2_rob_id", 64'(ROB_id_cdb[0 +: RW]), 64'd5);
    chk("t2_data", 64'(result_data_cdb[0 +: 32]), 64'hDEAD_BEEF);
    chk("t2_lane1_data", 64'(result_data_cdb[32 +: 32]), 64'h0);
    drain(2);

    // 3. contention from all four EUs with the scan restarted at EU0
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int e = 0; e < NUM_EU; e++) drive(e, 1'b1, 5'(e + 8), 32'hA000_0000 + 32'(e));
    cycle();
    idle();
    lat();
    chk("t3_c1_commit", 64'(commit_instr_cdb), 64'b11);
    chk("t3_c1_lane0", 64'(result_data_cdb[0 +: 32]), 64'hA000_0000);
    chk("t3_c1_lane1", 64'(result_data_cdb[32 +: 32]), 64'hA000_0001);
    cycle();
    chk("t3_c2_lane0", 64'(result_data_cdb[0 +: 32]), 64'hA000_0002);
    chk("t3_c2_lane1", 64'(result_data_cdb[32 +: 32]), 64'hA000_0003);
    cycle();
    chk("t3_c3_commit", 64'(commit_instr_cdb), 64'b00);
    // scan start is back at EU0, so EU0 precedes EU3
    drive(0, 1'b1, 5'd1, 32'hB000_0000);
    drive(3, 1'b1, 5'd2, 32'hB000_0003);
    cycle();
    idle();
    lat();
    chk("t3_rr_lane0", 64'(result_data_cdb[0 +: 32]), 64'hB000_0000);
    chk("t3_rr_lane1", 64'(result_data_cdb[32 +: 32]), 64'hB000_0003);
    drain(3);

    // 4. EU1 streams five results under full load; EU1 holds data while not ready
    obs.delete();
    base = pushed_cnt[1];
    for (int c = 0; c < 100 && (pushed_cnt[1] - base) < 5; c++) begin
      for (int e = 0; e < NUM_EU; e++)
        if (e != 1) drive(e, 1'b1, 5'($urandom), 32'h2000_0000 | (32'(e) << 16) | 32'(c));
      drive(1, 1'b1, 5'(pushed_cnt[1] - base), 32'h1100_0000 + 32'(pushed_cnt[1] - base));
      cycle();
    end
    chk("t4_accepted", 64'(pushed_cnt[1] - base), 64'd5);
    drain(10);
    got.delete();
    foreach (obs[i]) if (obs[i][31:24] == 8'h11) got.push_back(obs[i]);
    chk("t4_eu1_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("t4_eu1_order%0d", i), 64'(got[i]), 64'h1100_0000 + 64'(i));

    // 5. flush with three FIFOs nonempty and an EU0 push in the same cycle
    for (int e = 1; e < NUM_EU; e++) drive(e, 1'b1, 5'(e), 32'hC000_0000 + 32'(e));
    cycle();
    idle();
    obs.delete();
    flush = 1'b1;
    drive(0, 1'b1, 5'd7, 32'hF0F0_0000);
    cycle();
    flush = 1'b0;
    idle();
    chk("t5_commit_after_flush", 64'(commit_instr_cdb), 64'h0);
    chk("t5_rdy_after_flush", 64'(eu_rdy), 64'hF);
    drain(4);
    found = 0;
    foreach (obs[i]) if (obs[i] == 32'hF0F0_0000 || obs[i][31:24] == 8'hC0) found = 1;
    chk("t5_nothing_broadcast", 64'(found), 64'h0);

    // 6. fairness: EU0..EU2 kept loaded, EU3 gets one result
    for (int c = 0; c < 4; c++) begin
      for (int e = 0; e < 3; e++) drive(e, 1'b1, 5'($urandom), 32'h4000_0000 | (32'(e) << 16) | 32'(c));
      cycle();
    end
    obs.delete();
    drive(3, 1'b1, 5'd3, 32'h3300_0001);
    cycle();
    eu_val[3] = 1'b0;
    found = 0;
`ifdef CDB_OUT_REG_EN
    for (int c = 0; c < 3 && !found; c++) begin
`else
    for (int c = 0; c < 2 && !found; c++) begin
`endif
      for (int e = 0; e < 3; e++) drive(e, 1'b1, 5'($urandom), 32'h4100_0000 | (32'(e) << 16) | 32'(c));
      cycle();
      foreach (obs[i]) if (obs[i] == 32'h3300_0001) found = 1;
    end
    chk("t6_eu3_latency", 64'(found), 64'h1);
    drain(4);

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      for (int e = 0; e < NUM_EU; e++) drive(e, $urandom_range(0, 2) != 0, 5'($urandom), $urandom);
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cycle();
    end
    flush = 1'b0;
    rst   = 1'b0;
    drain(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
